// File: rtl/nios2_debug_vjtag_host.sv
// nios2_debug_vjtag_host: sld-hub emulator that drives a Nios II debug slave over the virtual-JTAG nets
module nios2_debug_vjtag_host #(
    parameter int IR_W     = 2,
    parameter int DR_W     = 38,
    parameter int TCK_HALF = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic            cmd_ir_en,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DR_W-1:0] rsp_dr,
    output logic            busy,
    output logic            vji_tck,
    output logic            vji_tdi,
    input  logic            vji_tdo,
    output logic [IR_W-1:0] vji_ir_in,
    output logic            vji_uir,
    output logic            vji_cdr,
    output logic            vji_sdr,
    output logic            vji_udr,
    output logic            vji_rti
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] UIR   = 3'd1;
    localparam logic [2:0] CDR   = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] UDR   = 3'd4;
    localparam logic [2:0] RTI   = 3'd5;
    localparam logic [2:0] RESP  = 3'd6;
    localparam int BW = $clog2(DR_W);

    logic [2:0]      state, next_state;
    logic [7:0]      ph;
    logic            half;
    logic [BW-1:0]   bc;
    logic [DR_W-1:0] sr;
    logic            tdo_q;
    logic            half_end, period_end, last_bit;

    assign half_end   = ph == 8'(TCK_HALF - 1);
    assign period_end = half_end && half;
    assign last_bit   = bc == BW'(DR_W - 1);
    assign cmd_ready  = state == IDLE && !rsp_valid;
    assign busy       = state != IDLE || rsp_valid;
    assign vji_tck    = half;
    assign vji_uir    = state == UIR;
    assign vji_cdr    = state == CDR;
    assign vji_sdr    = state == SHIFT;
    assign vji_udr    = state == UDR;
    assign vji_rti    = state == RTI;
    assign vji_tdi    = vji_sdr && sr[0];
    assign rsp_dr     = sr;

    // Virtual-state sequence taken at each tck period boundary
    always_comb begin
        next_state = state == UIR   ? CDR :
                     state == CDR   ? SHIFT :
                     state == SHIFT ? (last_bit ? UDR : SHIFT) :
                     state == UDR   ? RTI : RESP;
    end

    // Command accept, tck generation, DR shifting and response handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ph        <= '0;
            half      <= 1'b0;
            bc        <= '0;
            sr        <= '0;
            tdo_q     <= 1'b0;
            rsp_valid <= 1'b0;
            vji_ir_in <= '0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid && cmd_ready) begin
                    state <= cmd_ir_en ? UIR : CDR;
                    sr    <= cmd_dr;
                    if (cmd_ir_en) vji_ir_in <= cmd_ir;
                end
            end else if (state == RESP) begin
                rsp_valid <= 1'b1;
                state     <= IDLE;
            end else begin
                ph <= half_end ? '0 : ph + 8'd1;
                if (half_end) half <= !half;
                if (half_end && !half) tdo_q <= vji_tdo;
                if (period_end) begin
                    state <= next_state;
                    if (state == SHIFT) begin
                        sr <= {tdo_q, sr[DR_W-1:1]};
                        bc <= last_bit ? '0 : bc + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nios2_debug_vjtag_host.sv
// tb_nios2_debug_vjtag_host: checks two host builds (TCK_HALF 2 and 1) against a cycle-index model of the protocol
module tb_nios2_debug_vjtag_host;
    localparam int DR_W = 38;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] cmd_valid = '0, cmd_ir_en = '0, rsp_ready = 2'b11;
    logic [1:0] cmd_ready, rsp_valid, busy, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
    logic [1:0][1:0] cmd_ir = '0, ir_in;
    logic [1:0][DR_W-1:0] cmd_dr = '0, rsp_dr, pat = '0;
    logic [DR_W-1:0] m0 = '0, m1 = '0;

    logic [1:0] run = '0, rv = '0, hu = '0;
    int k[2], np[2];
    int cnt[5];
    logic [1:0][1:0] mir = '0;
    logic [1:0][DR_W-1:0] mdr = '0, mrsp = '0;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign tdo = {m1[0], m0[0]};

    nios2_debug_vjtag_host #(.TCK_HALF(2)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_ir(cmd_ir[0]), .cmd_ir_en(cmd_ir_en[0]), .cmd_dr(cmd_dr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_dr(rsp_dr[0]), .busy(busy[0]),
        .vji_tck(tck[0]), .vji_tdi(tdi[0]), .vji_tdo(tdo[0]), .vji_ir_in(ir_in[0]),
        .vji_uir(uir[0]), .vji_cdr(cdr[0]), .vji_sdr(sdr[0]), .vji_udr(udr[0]), .vji_rti(rti[0])
    );

    nios2_debug_vjtag_host #(.TCK_HALF(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_ir(cmd_ir[1]), .cmd_ir_en(cmd_ir_en[1]), .cmd_dr(cmd_dr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_dr(rsp_dr[1]), .busy(busy[1]),
        .vji_tck(tck[1]), .vji_tdi(tdi[1]), .vji_tdo(tdo[1]), .vji_ir_in(ir_in[1]),
        .vji_uir(uir[1]), .vji_cdr(cdr[1]), .vji_sdr(sdr[1]), .vji_udr(udr[1]), .vji_rti(rti[1])
    );

    // Debug-slave stand-ins: capture a pattern at CDR, shift it out LSB first on tck rise
    always @(posedge tck[0]) begin
        if (cdr[0]) m0 <= pat[0];
        else if (sdr[0]) m0 <= {tdi[0], m0[DR_W-1:1]};
    end

    always @(posedge tck[1]) begin
        if (cdr[1]) m1 <= pat[1];
        else if (sdr[1]) m1 <= {tdi[1], m1[DR_W-1:1]};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: expected outputs derived from the cycle index since accept, then advanced by the inputs
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int th, p, idx;
            logic [4:0] es, as;
            logic et, ei;
            th = d == 0 ? 2 : 1;
            es = '0;
            et = 1'b0;
            ei = 1'b0;
            if (run[d] && k[d] < np[d] * 2 * th) begin
                p   = k[d] / (2 * th);
                idx = hu[d] ? p : p + 1;
                et  = (k[d] % (2 * th)) >= th;
                es  = idx == 0 ? 5'b00001 : idx == 1 ? 5'b00010 : idx <= DR_W + 1 ? 5'b00100 :
                      idx == DR_W + 2 ? 5'b01000 : 5'b10000;
                ei  = (idx >= 2 && idx <= DR_W + 1) ? mdr[d][idx-2] : 1'b0;
            end
            as = {rti[d], udr[d], sdr[d], cdr[d], uir[d]};
            chk($sformatf("strobes[%0d]", d), 64'(as), 64'(es));
            chk($sformatf("tck[%0d]", d), 64'(tck[d]), 64'(et));
            chk($sformatf("tdi[%0d]", d), 64'(tdi[d]), 64'(ei));
            chk($sformatf("cmd_ready[%0d]", d), 64'(cmd_ready[d]), 64'(!run[d] && !rv[d]));
            chk($sformatf("rsp_valid[%0d]", d), 64'(rsp_valid[d]), 64'(rv[d]));
            chk($sformatf("busy[%0d]", d), 64'(busy[d]), 64'(run[d] || rv[d]));
            chk($sformatf("ir_in[%0d]", d), 64'(ir_in[d]), 64'(mir[d]));
            if (rv[d]) chk($sformatf("rsp_dr[%0d]", d), 64'(rsp_dr[d]), 64'(mrsp[d]));
            if (d == 0 && run[0]) for (int i = 0; i < 5; i++) cnt[i] += int'(as[i]);
            if (reset) begin
                run[d] = 1'b0;
                rv[d]  = 1'b0;
                mir[d] = '0;
            end else if (run[d]) begin
                k[d]++;
                if (k[d] == np[d] * 2 * th + 1) begin
                    run[d] = 1'b0;
                    rv[d]  = 1'b1;
                end
            end else if (rv[d]) begin
                if (rsp_ready[d]) rv[d] = 1'b0;
            end else if (cmd_valid[d]) begin
                run[d]  = 1'b1;
                k[d]    = 0;
                hu[d]   = cmd_ir_en[d];
                np[d]   = DR_W + 3 + int'(cmd_ir_en[d]);
                mdr[d]  = cmd_dr[d];
                mrsp[d] = pat[d];
                if (cmd_ir_en[d]) mir[d] = cmd_ir[d];
                if (d == 0) for (int i = 0; i < 5; i++) cnt[i] = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int d, input logic [1:0] ir, input logic en, input logic [DR_W-1:0] dr);
        cmd_ir[d]    = ir;
        cmd_ir_en[d] = en;
        cmd_dr[d]    = dr;
        cmd_valid[d] = 1'b1;
        cyc(1);
        cmd_valid[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, input int lat, input logic [DR_W-1:0] exp);
        int n = 0;
        while (!rsp_valid[d] && n < 400) begin
            cyc(1);
            n++;
        end
        chk($sformatf("latency[%0d]", d), 64'(n), 64'(lat));
        chk($sformatf("rsp_word[%0d]", d), 64'(rsp_dr[d]), 64'(exp));
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(2'b11));
        chk("reset_tck", 64'(tck), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_ir_in", 64'(ir_in), 64'(0));

        pat[0] = 38'h15_5555_5555;
        issue(0, 2'b01, 1'b1, 38'h2A_AAAA_AAAA);
        wait_rsp(0, 169, 38'h15_5555_5555);
        chk("ir_after_uir", 64'(ir_in[0]), 64'(2'b01));
        chk("cnt_uir", 64'(cnt[0]), 64'(4));
        chk("cnt_cdr", 64'(cnt[1]), 64'(4));
        chk("cnt_sdr", 64'(cnt[2]), 64'(152));
        chk("cnt_udr", 64'(cnt[3]), 64'(4));
        chk("cnt_rti", 64'(cnt[4]), 64'(4));

        cyc(1);
        pat[0] = 38'h3F_0000_FFFF;
        issue(0, 2'b10, 1'b0, 38'h12_3456_789A);
        wait_rsp(0, 165, 38'h3F_0000_FFFF);
        chk("ir_kept", 64'(ir_in[0]), 64'(2'b01));
        chk("cnt_uir_skip", 64'(cnt[0]), 64'(0));
        chk("cnt_sdr_skip", 64'(cnt[2]), 64'(152));

        cyc(1);
        rsp_ready[0] = 1'b0;
        pat[0] = 38'h00_DEAD_BEEF;
        issue(0, 2'b11, 1'b1, 38'h3F_FFFF_FFFF);
        wait_rsp(0, 169, 38'h00_DEAD_BEEF);
        cmd_ir[0]    = 2'b10;
        cmd_ir_en[0] = 1'b1;
        cmd_dr[0]    = 38'h01_2345_6789;
        cmd_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("hold_cmd_ready", 64'(cmd_ready[0]), 64'(0));
            chk("hold_rsp_dr", 64'(rsp_dr[0]), 64'(38'h00_DEAD_BEEF));
        end
        rsp_ready[0] = 1'b1;
        cyc(1);
        chk("consumed_rsp_valid", 64'(rsp_valid[0]), 64'(0));
        chk("consumed_cmd_ready", 64'(cmd_ready[0]), 64'(1));
        cyc(1);
        cmd_valid[0] = 1'b0;
        chk("b2b_busy", 64'(busy[0]), 64'(1));
        chk("b2b_cmd_ready", 64'(cmd_ready[0]), 64'(0));
        wait_rsp(0, 169, 38'h00_DEAD_BEEF);
        chk("ir_b2b", 64'(ir_in[0]), 64'(2'b10));

        cyc(1);
        pat[0] = 38'h15_5555_5555;
        issue(0, 2'b01, 1'b1, 38'h2A_AAAA_AAAA);
        cyc(48);
        chk("abort_in_sdr", 64'(sdr[0]), 64'(1));
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("abort_strobes", 64'({rti[0], udr[0], sdr[0], cdr[0], uir[0]}), 64'(0));
        chk("abort_tck", 64'(tck[0]), 64'(0));
        chk("abort_cmd_ready", 64'(cmd_ready[0]), 64'(1));
        cyc(200);
        chk("abort_no_rsp", 64'(rsp_valid[0]), 64'(0));

        pat[1] = 38'h15_5555_5555;
        issue(1, 2'b01, 1'b1, 38'h2A_AAAA_AAAA);
        wait_rsp(1, 85, 38'h15_5555_5555);
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
